// File: rtl/mips_mcp_core.sv
// mips_mcp_core: multicycle MIPS-32 core with one shared memory port.
//
// A control FSM steps each instruction through FETCH/DECODE and then a
// short, instruction-specific state sequence. Fetches and data accesses
// share one request/ready port, and any request may stall on wait states.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   mem_req/mem_we     access request and write strobe (we only with req)
//   mem_addr           byte address (low ADDR_WIDTH bits of PC or ALUOut)
//   mem_wdata          store data (B register)
//   mem_rdata          fetch/load data, sampled when mem_ready=1
//   mem_ready          the pending access completes this cycle
//   PC, Instr          program counter and instruction register
//   ALUResult          ALUOut register
//   WriteData          B register (rt operand)
//   ReadData           memory data register (MDR)
//   RegWrite           register-file write enable this cycle
//   illegal_instr      one-cycle pulse in DECODE on an unsupported encoding
module mips_mcp_core #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output logic [31:0]           PC,
  output logic [31:0]           Instr,
  output logic [31:0]           ALUResult,
  output logic [31:0]           WriteData,
  output logic [31:0]           ReadData,
  output logic                  RegWrite,
  output logic                  illegal_instr
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_JAL, S_JR
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q, ir_q, a_q, b_q, aluout_q, mdr_q;
  logic [31:0] rf_q [32];

  logic [5:0]  op_s, funct_s;
  logic [4:0]  rs_s, rt_s, rd_s;
  logic [31:0] simm_s, jtarget_s, rs_val_s, rt_val_s, alu_s, addr_full_s;
  logic        legal_s;
  state_t      dispatch_s;
  logic        wb_en_s;
  logic [4:0]  wb_addr_s;
  logic [31:0] wb_data_s;

  assign op_s    = ir_q[31:26];
  assign rs_s    = ir_q[25:21];
  assign rt_s    = ir_q[20:16];
  assign rd_s    = ir_q[15:11];
  assign funct_s = ir_q[5:0];
  assign simm_s  = {{16{ir_q[15]}}, ir_q[15:0]};
  // pc_q already holds PC+4 after FETCH, so the upper nibble is the MIPS one
  assign jtarget_s = {pc_q[31:28], ir_q[25:0], 2'b00};

  // $0 is hard-wired to zero regardless of array contents
  assign rs_val_s = (rs_s == 5'd0) ? 32'd0 : rf_q[rs_s];
  assign rt_val_s = (rt_s == 5'd0) ? 32'd0 : rf_q[rt_s];

  // Decode legality and the state to enter after DECODE
  always_comb begin
    legal_s    = 1'b1;
    dispatch_s = S_FETCH;
    case (op_s)
      OP_RTYPE: begin
        case (funct_s)
          FN_JR:                                         dispatch_s = S_JR;
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_NOR, FN_SLT: dispatch_s = S_EXEC;
          default:                                       legal_s = 1'b0;
        endcase
      end
      OP_LW, OP_SW: dispatch_s = S_MEMADR;
      OP_BEQ:       dispatch_s = S_BRANCH;
      OP_ADDI:      dispatch_s = S_ADDIEX;
      OP_J:         dispatch_s = S_JUMP;
      OP_JAL:       dispatch_s = S_JAL;
      default:      legal_s = 1'b0;
    endcase
  end

  // R-type ALU operation on the A/B operand registers
  always_comb begin
    case (funct_s)
      FN_ADD:  alu_s = a_q + b_q;
      FN_SUB:  alu_s = a_q - b_q;
      FN_AND:  alu_s = a_q & b_q;
      FN_OR:   alu_s = a_q | b_q;
      FN_NOR:  alu_s = ~(a_q | b_q);
      FN_SLT:  alu_s = ($signed(a_q) < $signed(b_q)) ? 32'd1 : 32'd0;
      default: alu_s = 32'd0;
    endcase
  end

  // Register-file write port selection per write-back state
  always_comb begin
    wb_en_s   = 1'b0;
    wb_addr_s = 5'd0;
    wb_data_s = 32'd0;
    case (state_q)
      S_MEMWB:  begin wb_en_s = 1'b1; wb_addr_s = rt_s;  wb_data_s = mdr_q;    end
      S_ALUWB:  begin wb_en_s = 1'b1; wb_addr_s = rd_s;  wb_data_s = aluout_q; end
      S_ADDIWB: begin wb_en_s = 1'b1; wb_addr_s = rt_s;  wb_data_s = aluout_q; end
      S_JAL:    begin wb_en_s = 1'b1; wb_addr_s = 5'd31; wb_data_s = pc_q;     end
      default:  begin wb_en_s = 1'b0; wb_addr_s = 5'd0;  wb_data_s = 32'd0;    end
    endcase
  end

  // Gating with reset makes a mid-instruction reset drop the request and
  // suppress any write in the very cycle it is raised.
  assign RegWrite      = wb_en_s && (wb_addr_s != 5'd0) && !reset;
  assign illegal_instr = (state_q == S_DECODE) && !legal_s && !reset;
  assign mem_req       = ((state_q == S_FETCH) || (state_q == S_MEMRD) ||
                          (state_q == S_MEMWR)) && !reset;
  assign mem_we        = (state_q == S_MEMWR) && !reset;
  // Address and store data come straight from registers, so they hold
  // steady through any number of stall cycles.
  assign addr_full_s   = (state_q == S_FETCH) ? pc_q : aluout_q;
  assign mem_addr      = addr_full_s[ADDR_WIDTH-1:0];
  assign mem_wdata     = b_q;

  assign PC        = pc_q;
  assign Instr     = ir_q;
  assign ALUResult = aluout_q;
  assign WriteData = b_q;
  assign ReadData  = mdr_q;

  // Register-file synchronous write port
  always_ff @(posedge clk) begin
    if (RegWrite) begin
      rf_q[wb_addr_s] <= wb_data_s;
    end
  end

  // Control FSM and architectural registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      ir_q     <= 32'd0;
      a_q      <= 32'd0;
      b_q      <= 32'd0;
      aluout_q <= 32'd0;
      mdr_q    <= 32'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (mem_ready) begin
            ir_q    <= mem_rdata;
            pc_q    <= pc_q + 32'd4;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_q      <= rs_val_s;
          b_q      <= rt_val_s;
          aluout_q <= pc_q + (simm_s << 2);
          state_q  <= dispatch_s;
        end
        S_MEMADR: begin
          aluout_q <= a_q + simm_s;
          state_q  <= (op_s == OP_LW) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          if (mem_ready) begin
            mdr_q   <= mem_rdata;
            state_q <= S_MEMWB;
          end
        end
        S_MEMWR: begin
          if (mem_ready) begin
            state_q <= S_FETCH;
          end
        end
        S_EXEC: begin
          aluout_q <= alu_s;
          state_q  <= S_ALUWB;
        end
        S_ADDIEX: begin
          aluout_q <= a_q + simm_s;
          state_q  <= S_ADDIWB;
        end
        S_BRANCH: begin
          if (a_q == b_q) begin
            pc_q <= aluout_q;
          end
          state_q <= S_FETCH;
        end
        S_JUMP, S_JAL: begin
          pc_q    <= jtarget_s;
          state_q <= S_FETCH;
        end
        S_JR: begin
          pc_q    <= a_q;
          state_q <= S_FETCH;
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mcp_core.sv
// Directed bench for mips_mcp_core with a wait-state memory model.
module tb_mips_mcp_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;
  logic [31:0] PC, Instr, ALUResult, WriteData, ReadData;
  logic        RegWrite, illegal_instr;

  mips_mcp_core #(.RESET_PC(32'h0000_0040), .ADDR_WIDTH(32)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .PC(PC), .Instr(Instr), .ALUResult(ALUResult), .WriteData(WriteData),
    .ReadData(ReadData), .RegWrite(RegWrite), .illegal_instr(illegal_instr)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] mem [0:255];
  int          wait_n = 0;
  int          wait_cnt = 0;
  logic        chk_stable = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: decides ready/rdata on the falling edge for the next rising edge
  initial forever begin
    @(negedge clk);
    if (mem_req) begin
      if (chk_stable && prev_stall) begin
        check("stall_addr_stable", mem_addr, prev_addr);
        check("stall_wdata_stable", mem_wdata, prev_wdata);
      end
      if (wait_cnt < wait_n) begin
        mem_ready  = 1'b0;
        wait_cnt++;
        prev_stall = 1'b1;
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
      end else begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
        if (mem_we) mem[mem_addr[9:2]] = mem_wdata;
        wait_cnt   = 0;
        prev_stall = 1'b0;
      end
    end else begin
      // Ready and junk data while idle: the core must ignore both
      mem_ready  = 1'b1;
      mem_rdata  = 32'hBAD0_BAD0;
      wait_cnt   = 0;
      prev_stall = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
  endtask

  // Hold reset two cycles, check reset values, release into cycle 1 of FETCH
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    check("rst_PC", PC, 32'h0000_0040);
    check("rst_Instr", Instr, 32'd0);
    check("rst_ALUResult", ALUResult, 32'd0);
    check("rst_WriteData", WriteData, 32'd0);
    check("rst_ReadData", ReadData, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_RegWrite", {31'd0, RegWrite}, 32'd0);
    check("rst_illegal", {31'd0, illegal_instr}, 32'd0);
    reset = 1'b0;
    #1;
    check("first_req", {31'd0, mem_req}, 32'd1);
    check("first_addr", mem_addr, 32'h0000_0040);
    check("first_we", {31'd0, mem_we}, 32'd0);
  endtask

  task automatic load_prog1();
    clear_mem();
    mem[16] = 32'h2001_0005; // 0x40 addi $1,$0,5
    mem[17] = 32'h2002_FFFD; // 0x44 addi $2,$0,-3
    mem[18] = 32'h0022_1820; // 0x48 add  $3,$1,$2
    mem[19] = 32'h0041_202A; // 0x4C slt  $4,$2,$1
    mem[20] = 32'hAC03_0008; // 0x50 sw   $3,8($0)
    mem[21] = 32'h8C05_0008; // 0x54 lw   $5,8($0)
    mem[22] = 32'h0800_0016; // 0x58 j    0x58
  endtask

  // Cycles counted from the first post-reset cycle up to and including
  // the cycle that presents the fetch of 0x58.
  task automatic run_prog1(input string tag, input int exp_cycles);
    int n;
    load_prog1();
    do_reset();
    n = 1;
    while (!(mem_req && !mem_we && mem_addr == 32'h58) && n < 300) begin
      step();
      n++;
    end
    check({tag, "_cycles"}, n, exp_cycles);
    check({tag, "_mem8"}, mem[2], 32'd2);
    check({tag, "_r1"}, dut.rf_q[1], 32'd5);
    check({tag, "_r2"}, dut.rf_q[2], 32'hFFFF_FFFD);
    check({tag, "_r3"}, dut.rf_q[3], 32'd2);
    check({tag, "_r4"}, dut.rf_q[4], 32'd1);
    check({tag, "_r5"}, dut.rf_q[5], 32'd2);
    check({tag, "_Instr"}, Instr, 32'h8C05_0008);
    check({tag, "_ReadData"}, ReadData, 32'd2);
    check({tag, "_ALUResult"}, ALUResult, 32'd8);
  endtask

  logic [31:0] exp_fa [13] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h48, 32'h4C,
                               32'h50, 32'h100, 32'h200, 32'h104, 32'h108,
                               32'h10C, 32'h110};
  int          exp_fc [13] = '{1, 5, 9, 13, 16, 20, 23, 26, 29, 32, 36, 40, 42};

  initial begin
    logic [31:0] fa [16];
    int          fc [16];
    int          nf, n_rw, n_ill, n;
    logic        prev_fetch, found;
    logic [31:0] pc_ill;

    // Program 1 with 3 wait states on every access, then with none
    wait_n = 3;
    chk_stable = 1'b1;
    run_prog1("ws3", 50);
    chk_stable = 1'b0;
    wait_n = 0;
    run_prog1("ws0", 26);

    // Program 2: branches, jumps, $0 write, illegal opcode
    clear_mem();
    mem[16]  = 32'h2002_0001; // 0x40 addi $2,$0,1
    mem[17]  = 32'h2001_0000; // 0x44 addi $1,$0,0
    mem[18]  = 32'h2021_0001; // 0x48 addi $1,$1,1
    mem[19]  = 32'h1022_FFFE; // 0x4C beq  $1,$2,-2
    mem[20]  = 32'h0800_0040; // 0x50 j    0x100
    mem[64]  = 32'h0C00_0080; // 0x100 jal 0x200
    mem[128] = 32'h03E0_0008; // 0x200 jr  $31
    mem[65]  = 32'h2000_0007; // 0x104 addi $0,$0,7
    mem[66]  = 32'h0000_3020; // 0x108 add  $6,$0,$0
    mem[67]  = 32'hFC00_0000; // 0x10C opcode 3F
    mem[68]  = 32'h0800_0044; // 0x110 j    0x110
    do_reset();
    nf = 0; n_rw = 0; n_ill = 0; prev_fetch = 1'b0; pc_ill = 32'd0;
    for (int c = 1; c <= 44; c++) begin
      if (mem_req && !mem_we && !prev_fetch && nf < 16) begin
        fa[nf] = mem_addr;
        fc[nf] = c;
        nf++;
      end
      prev_fetch = mem_req && !mem_we;
      if (RegWrite) n_rw++;
      if (illegal_instr) begin
        n_ill++;
        pc_ill = PC;
      end
      step();
    end
    check("p2_nfetch", nf, 13);
    for (int i = 0; i < 13; i++) begin
      check($sformatf("p2_fetch_addr%0d", i), fa[i], exp_fa[i]);
      check($sformatf("p2_fetch_cyc%0d", i), fc[i], exp_fc[i]);
    end
    check("p2_regwrite_cnt", n_rw, 6);
    check("p2_illegal_cnt", n_ill, 1);
    check("p2_illegal_pc", pc_ill, 32'h110);
    check("p2_r31", dut.rf_q[31], 32'h104);
    check("p2_r1", dut.rf_q[1], 32'd2);
    check("p2_r2", dut.rf_q[2], 32'd1);
    check("p2_r6", dut.rf_q[6], 32'd0);

    // Program 3: reset during a lw stall must leave $1 untouched
    clear_mem();
    mem[16] = 32'h8C01_0008; // 0x40 lw $1,8($0)
    mem[2]  = 32'hDEAD_BEEF;
    wait_n = 10;
    do_reset();
    n = 1;
    found = 1'b0;
    while (!found && n < 80) begin
      if (mem_req && !mem_we && mem_addr == 32'h8) found = 1'b1;
      else begin
        step();
        n++;
      end
    end
    check("p3_reached_memrd", {31'd0, found}, 32'd1);
    step();
    step();
    check("p3_stalling", {31'd0, mem_req}, 32'd1);
    reset = 1'b1;
    #1;
    check("p3_req_drop", {31'd0, mem_req}, 32'd0);
    step();
    check("p3_pc_reset", PC, 32'h40);
    check("p3_r1_kept", dut.rf_q[1], 32'd2);
    check("p3_readdata", ReadData, 32'd0);
    wait_n = 0;
    do_reset();
    check("p3_r1_final", dut.rf_q[1], 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
